// File: rtl/pyjamask96_host_if.sv
// Host-side driver for the byte-serial Pyjamask-96 core: parallel key/plaintext in,
// byte streams to the core, 12 ciphertext bytes collected back, watchdog on silence.
module pyjamask96_host_if #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [95:0]  req_pt,
  output logic         load,
  output logic         load_key,
  output logic [7:0]   byte_key_in,
  output logic         load_state,
  output logic [7:0]   byte_in,
  output logic         start,
  input  logic         core_valid,
  input  logic [7:0]   core_byte_out,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [95:0]  resp_ct,
  output logic         resp_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND_KEY, S_SEND_STATE, S_START, S_COLLECT, S_RESP
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t       r_state;
  logic [127:0] r_key;
  logic [95:0]  r_pt;
  logic [3:0]   r_cnt;
  logic [7:0]   r_wd;
  logic         r_req_ready;
  logic         r_load;
  logic         r_load_key;
  logic [7:0]   r_byte_key_in;
  logic         r_load_state;
  logic [7:0]   r_byte_in;
  logic         r_start;
  logic         r_resp_valid;
  logic [95:0]  r_resp_ct;
  logic         r_resp_timeout;

  // reset_n is active-high in this codebase despite its name
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state        <= S_IDLE;
      r_key          <= '0;
      r_pt           <= '0;
      r_cnt          <= '0;
      r_wd           <= '0;
      r_req_ready    <= 1'b0;
      r_load         <= 1'b0;
      r_load_key     <= 1'b0;
      r_byte_key_in  <= '0;
      r_load_state   <= 1'b0;
      r_byte_in      <= '0;
      r_start        <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_ct      <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_key          <= req_key;
            r_pt           <= req_pt;
            r_resp_ct      <= '0;
            r_resp_timeout <= 1'b0;
            r_req_ready    <= 1'b0;
            r_load         <= 1'b1;
            r_state        <= S_LOAD;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          r_load_key    <= 1'b1;
          r_byte_key_in <= r_key[127:120];
          r_key         <= {r_key[119:0], 8'h00};
          r_cnt         <= '0;
          r_state       <= S_SEND_KEY;
        end
        S_SEND_KEY: begin
          if (r_cnt == 4'd15) begin
            r_load_key    <= 1'b0;
            r_byte_key_in <= '0;
            r_load_state  <= 1'b1;
            r_byte_in     <= r_pt[95:88];
            r_pt          <= {r_pt[87:0], 8'h00};
            r_cnt         <= '0;
            r_state       <= S_SEND_STATE;
          end else begin
            r_byte_key_in <= r_key[127:120];
            r_key         <= {r_key[119:0], 8'h00};
            r_cnt         <= r_cnt + 4'd1;
          end
        end
        S_SEND_STATE: begin
          if (r_cnt == 4'd11) begin
            r_load_state <= 1'b0;
            r_byte_in    <= '0;
            r_start      <= 1'b1;
            r_state      <= S_START;
          end else begin
            r_byte_in <= r_pt[95:88];
            r_pt      <= {r_pt[87:0], 8'h00};
            r_cnt     <= r_cnt + 4'd1;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_wd    <= '0;
          r_state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (core_valid) begin
            r_resp_ct <= {r_resp_ct[87:0], core_byte_out};
            r_wd      <= '0;
            r_cnt     <= r_cnt + 4'd1;
            if (r_cnt == 4'd11) begin
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end
          end else if (r_wd == WD_LAST) begin
            // TIMEOUT consecutive silent cycles: return what was gathered
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign load         = r_load;
  assign load_key     = r_load_key;
  assign byte_key_in  = r_byte_key_in;
  assign load_state   = r_load_state;
  assign byte_in      = r_byte_in;
  assign start        = r_start;
  assign resp_valid   = r_resp_valid;
  assign resp_ct      = r_resp_ct;
  assign resp_timeout = r_resp_timeout;

endmodule
